// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester, serializer and status signals of the UART TX arbiter.
//            The master side drives the requests and the busy flag, the slave
//            side is the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int c_ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [c_ID_W-1:0]    grant_id;
    logic                 locked;
    logic                 err_timeout;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, locked, err_timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, locked, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter feeding bytes from NUM_REQ requesters into a
//            single UART serializer. A requester that sends a byte without
//            its last flag keeps the serializer until its message closes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [7:0]          r_tx_data,  w_tx_data_nxt;
    logic                r_tx_start, w_tx_start_nxt;
    logic [c_ID_W-1:0]   r_grant_id, w_grant_id_nxt;
    logic [c_ID_W-1:0]   r_ptr,      w_ptr_nxt;
    logic                r_locked,   w_locked_nxt;
    logic                r_err,      w_err_nxt;
    logic [c_CNT_W-1:0]  r_cnt,      w_cnt_nxt;

    logic [c_ID_W-1:0]   w_sel;
    logic                w_found;
    logic                w_gate;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [7:0]          w_sel_byte;
    logic                w_accept;

    // Candidate requester: the lock owner, or the first valid index after ptr.
    always_comb begin : sel_search
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_sel   = r_grant_id;
        if (!r_locked) begin
            // With nothing valid the offer parks on ptr+1 so exactly one bit is up.
            w_sel = c_ID_W'((int'(r_ptr) + 1) % NUM_REQ);
            for (int k = 1; k <= NUM_REQ; k++) begin
                v_idx = (int'(r_ptr) + k) % NUM_REQ;
                if (!w_found && bus.req_valid[v_idx]) begin
                    w_found = 1'b1;
                    w_sel   = c_ID_W'(v_idx);
                end
            end
        end
    end

    // Offer the slot only while idle, serializer free and out of reset.
    always_comb begin
        w_gate        = (r_state == S_IDLE) && !bus.tx_busy && !rst;
        bus.req_ready = '0;
        w_sel_valid   = 1'b0;
        w_sel_last    = 1'b0;
        w_sel_byte    = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == c_ID_W'(i)) begin
                bus.req_ready[i] = w_gate;
                w_sel_valid      = bus.req_valid[i];
                w_sel_last       = bus.req_last[i];
                w_sel_byte       = bus.req_data[8*i +: 8];
            end
        end
        w_accept = w_gate && w_sel_valid;
    end

    // Next-state and next-output logic for the transmit handshake.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_data_nxt  = r_tx_data;
        w_tx_start_nxt = r_tx_start;
        w_grant_id_nxt = r_grant_id;
        w_ptr_nxt      = r_ptr;
        w_locked_nxt   = r_locked;
        w_err_nxt      = 1'b0;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_tx_data_nxt  = w_sel_byte;
                    w_grant_id_nxt = w_sel;
                    w_locked_nxt   = !w_sel_last;
                    w_tx_start_nxt = 1'b1;
                    // The counter holds the number of the current START cycle.
                    w_cnt_nxt      = c_CNT_W'(1);
                    w_state_nxt    = S_START;
                end
            end
            S_START: begin
                if (bus.tx_busy) begin
                    w_tx_start_nxt = 1'b0;
                    w_state_nxt    = S_WAIT_DONE;
                end else if (r_cnt == c_CNT_W'(BUSY_TIMEOUT)) begin
                    // Give up on the byte and let the next requester in.
                    w_tx_start_nxt = 1'b0;
                    w_locked_nxt   = 1'b0;
                    w_ptr_nxt      = r_grant_id;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    // Registered, so the pulse lands in START cycle BUSY_TIMEOUT.
                    w_err_nxt = (r_cnt == c_CNT_W'(BUSY_TIMEOUT - 1));
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    w_state_nxt = S_IDLE;
                    if (!r_locked) begin
                        w_ptr_nxt = r_grant_id;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers; ptr resets to the top so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_grant_id <= '0;
            r_ptr      <= c_ID_W'(NUM_REQ - 1);
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_locked   <= w_locked_nxt;
            r_err      <= w_err_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign bus.tx_data     = r_tx_data;
    assign bus.tx_start    = r_tx_start;
    assign bus.grant_id    = r_grant_id;
    assign bus.locked      = r_locked;
    assign bus.err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter: directed scenarios plus a
//            randomized run against a cycle-level reference of the handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int c_NUM_REQ = 4;
    localparam int c_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(c_NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (c_NUM_REQ),
        .BUSY_TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Per-requester message queues for directed steps: {last, data}.
    logic [8:0] msg [c_NUM_REQ][16];
    int         q_head [c_NUM_REQ];
    int         q_tail [c_NUM_REQ];

    // Observed transmissions, captured when tx_start rises.
    int         log_id [$];
    int         log_data [$];
    int         log_lock [$];

    bit         rand_mode;
    bit         ser_auto;
    int         ser_delay, ser_frame, ser_wait, ser_left;

    // Reference: phase 0 idle, 1 waiting for busy, 2 waiting for busy to drop.
    int         m_phase, m_cnt, m_ptr, m_grant;
    bit         m_locked, m_start, m_err;
    int         m_txdata;

    bit         p_rst, p_busy, p_acc, p_last;
    int         p_idx, p_data;
    logic [c_NUM_REQ-1:0] act_acc;
    bit         prev_start;
    int         cyc, start_cyc, err_cyc, err_count;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(int i, int d, bit l);
        msg[i][q_tail[i]] = {l, d[7:0]};
        q_tail[i]++;
    endtask

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int i = 0; i < c_NUM_REQ; i++) if (q_head[i] != q_tail[i]) e = 1'b0;
        return e;
    endfunction

    task automatic clear_log();
        log_id.delete();
        log_data.delete();
        log_lock.delete();
    endtask

    task automatic drive_inputs();
        logic [8:0] m;
        for (int i = 0; i < c_NUM_REQ; i++) begin
            if (rand_mode) begin
                bus.req_valid[i]        = ($urandom_range(0, 99) < 60);
                bus.req_data[8*i +: 8]  = 8'($urandom);
                bus.req_last[i]         = ($urandom_range(0, 2) == 0);
            end else if (q_head[i] != q_tail[i]) begin
                m = msg[i][q_head[i]];
                bus.req_valid[i]        = 1'b1;
                bus.req_data[8*i +: 8]  = m[7:0];
                bus.req_last[i]         = m[8];
            end else begin
                bus.req_valid[i]        = 1'b0;
                bus.req_data[8*i +: 8]  = 8'h00;
                bus.req_last[i]         = 1'b0;
            end
        end
    endtask

    // One clock: check the combinational offer, advance the reference at the
    // edge, check registered outputs, then let the serializer react.
    task automatic step();
        logic [c_NUM_REQ-1:0] exp_ready;
        int  sel, j;
        bit  known;
        drive_inputs();
        #1;
        exp_ready = '0;
        known     = 1'b1;
        sel       = -1;
        if (!rst && m_phase == 0 && !bus.tx_busy) begin
            if (m_locked) sel = m_grant;
            else begin
                for (int k = 1; k <= c_NUM_REQ; k++) begin
                    j = (m_ptr + k) % c_NUM_REQ;
                    if (sel < 0 && bus.req_valid[j]) sel = j;
                end
                if (sel < 0) known = 1'b0;
            end
            if (sel >= 0) exp_ready[sel] = 1'b1;
        end
        if (known) check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        act_acc = bus.req_valid & bus.req_ready;
        p_acc   = (sel >= 0) && bus.req_valid[sel];
        p_idx   = sel;
        if (sel >= 0) begin
            p_data = int'(bus.req_data[8*sel +: 8]);
            p_last = bus.req_last[sel];
        end
        p_rst  = rst;
        p_busy = bus.tx_busy;

        @(posedge clk);
        #1;
        cyc++;
        if (p_rst) begin
            m_phase = 0; m_cnt = 0; m_ptr = c_NUM_REQ - 1; m_grant = 0;
            m_locked = 1'b0; m_start = 1'b0; m_txdata = 0;
        end else if (p_acc) begin
            m_phase = 1; m_cnt = 1; m_grant = p_idx;
            m_locked = !p_last; m_txdata = p_data; m_start = 1'b1;
        end else if (m_phase == 1) begin
            if (p_busy) begin
                m_phase = 2; m_start = 1'b0;
            end else if (m_cnt == c_TIMEOUT) begin
                m_phase = 0; m_start = 1'b0; m_locked = 1'b0; m_ptr = m_grant;
            end else m_cnt++;
        end else if (m_phase == 2 && !p_busy) begin
            m_phase = 0;
            if (!m_locked) m_ptr = m_grant;
        end
        m_err = !p_rst && (m_phase == 1) && (m_cnt == c_TIMEOUT) && !p_acc;

        check("tx_start",    32'(bus.tx_start),    32'(m_start));
        check("tx_data",     32'(bus.tx_data),     32'(m_txdata));
        check("grant_id",    32'(bus.grant_id),    32'(m_grant));
        check("locked",      32'(bus.locked),      32'(m_locked));
        check("err_timeout", 32'(bus.err_timeout), 32'(m_err));

        if (bus.tx_start && !prev_start) begin
            log_id.push_back(int'(bus.grant_id));
            log_data.push_back(int'(bus.tx_data));
            log_lock.push_back(int'(bus.locked));
            start_cyc = cyc;
        end
        prev_start = bus.tx_start;
        if (bus.err_timeout) begin
            err_count++;
            err_cyc = cyc;
        end
        if (!rand_mode)
            for (int i = 0; i < c_NUM_REQ; i++) if (act_acc[i]) q_head[i]++;

        if (ser_auto) begin
            if (ser_left > 0) begin
                ser_left--;
                if (ser_left == 0) bus.tx_busy = 1'b0;
            end else if (bus.tx_start && !bus.tx_busy) begin
                if (ser_wait >= ser_delay) begin
                    bus.tx_busy = 1'b1;
                    ser_left    = ser_frame;
                    ser_wait    = 0;
                    if (rand_mode) begin
                        ser_delay = $urandom_range(0, 3);
                        ser_frame = $urandom_range(2, 6);
                    end
                end else ser_wait++;
            end
        end
    endtask

    task automatic run_until(int n, int budget, string tag);
        int c = 0;
        while (!(log_id.size() >= n && m_phase == 0 && queues_empty()) && c < budget) begin
            step();
            c++;
        end
        check(tag, 32'(c < budget), 32'd1);
    endtask

    task automatic check_log(string tag, int k, int id, int data);
        if (log_id.size() > k) begin
            check(tag, 32'(log_id[k]),   32'(id));
            check(tag, 32'(log_data[k]), 32'(data));
        end else check(tag, 32'(log_id.size()), 32'(k + 1));
    endtask

    initial begin
        int c;
        for (int i = 0; i < c_NUM_REQ; i++) begin
            q_head[i] = 0;
            q_tail[i] = 0;
        end
        rand_mode = 1'b0; ser_auto = 1'b1; ser_delay = 0; ser_frame = 10;
        ser_wait = 0; ser_left = 0; prev_start = 1'b0;
        cyc = 0; start_cyc = 0; err_cyc = 0; err_count = 0;
        m_phase = 0; m_cnt = 0; m_ptr = c_NUM_REQ - 1; m_grant = 0;
        m_locked = 1'b0; m_start = 1'b0; m_err = 1'b0; m_txdata = 0;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_busy = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Simultaneous requests from 0 and 2
        clear_log();
        push(0, 8'h41, 1'b1); push(2, 8'h43, 1'b1);
        run_until(2, 80, "simul_done");
        check_log("simul_first", 0, 0, 8'h41);
        check_log("simul_second", 1, 2, 8'h43);

        // Wrap-around: serve 3 so ptr=3, then 0 must beat 3
        ser_frame = 4;
        clear_log();
        push(3, 8'h51, 1'b1);
        run_until(1, 40, "wrap_setup");
        clear_log();
        push(0, 8'h50, 1'b1); push(3, 8'h52, 1'b1);
        run_until(2, 60, "wrap_done");
        check_log("wrap_first", 0, 0, 8'h50);
        check_log("wrap_second", 1, 3, 8'h52);

        // Lock: requester 1 keeps the serializer across its two-byte message
        clear_log();
        push(0, 8'h20, 1'b1); push(0, 8'h30, 1'b1);
        push(1, 8'h68, 1'b0); push(1, 8'h69, 1'b1);
        run_until(4, 120, "lock_done");
        check_log("lock_b0", 0, 0, 8'h20);
        check_log("lock_b1", 1, 1, 8'h68);
        check_log("lock_b2", 2, 1, 8'h69);
        check_log("lock_b3", 3, 0, 8'h30);
        if (log_lock.size() >= 3) begin
            check("lock_open",  32'(log_lock[1]), 32'd1);
            check("lock_close", 32'(log_lock[2]), 32'd0);
        end

        // Busy gating: nothing accepted while tx_busy is high in IDLE
        clear_log();
        ser_auto = 1'b0;
        bus.tx_busy = 1'b1;
        push(1, 8'h11, 1'b1);
        repeat (6) step();
        check("gated_nostart", 32'(log_id.size()), 32'd0);
        bus.tx_busy = 1'b0;
        ser_auto = 1'b1;
        run_until(1, 40, "gated_done");
        check_log("gated_byte", 0, 1, 8'h11);

        // Timeout: serializer never answers
        clear_log();
        ser_auto = 1'b0;
        bus.tx_busy = 1'b0;
        err_count = 0;
        push(2, 8'h77, 1'b0);
        c = 0;
        while (err_count == 0 && c < 60) begin
            step();
            c++;
        end
        check("timeout_seen", 32'(err_count), 32'd1);
        check("timeout_cycle", 32'(err_cyc - start_cyc), 32'(c_TIMEOUT - 1));
        if (log_lock.size() > 0) check("timeout_locked_before", 32'(log_lock[0]), 32'd1);
        step();
        check("timeout_start_clr", 32'(bus.tx_start), 32'd0);
        check("timeout_unlock", 32'(bus.locked), 32'd0);
        repeat (2) step();
        check("timeout_single_pulse", 32'(err_count), 32'd1);
        // ptr moved to 2, so 3 is searched before 1
        ser_auto = 1'b1;
        clear_log();
        push(1, 8'h81, 1'b1); push(3, 8'h83, 1'b1);
        run_until(2, 60, "after_to_done");
        check_log("after_to_first", 0, 3, 8'h83);
        check_log("after_to_second", 1, 1, 8'h81);

        // Reset in WAIT_DONE
        clear_log();
        push(2, 8'h99, 1'b1);
        c = 0;
        while (m_phase != 2 && c < 30) begin
            step();
            c++;
        end
        check("rst_reach_wait", 32'(c < 30), 32'd1);
        push(3, 8'hA3, 1'b1); push(0, 8'hA0, 1'b1);
        bus.tx_busy = 1'b0; ser_left = 0; ser_wait = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data",  32'(bus.tx_data),  32'd0);
        check("rst_grant",    32'(bus.grant_id), 32'd0);
        check("rst_locked",   32'(bus.locked),   32'd0);
        clear_log();
        run_until(2, 60, "rst_done");
        check_log("rst_first", 0, 0, 8'hA0);
        check_log("rst_second", 1, 3, 8'hA3);

        // Randomized traffic against the reference
        rst = 1'b1;
        step();
        rst = 1'b0;
        rand_mode = 1'b1;
        ser_delay = 1; ser_frame = 3;
        clear_log();
        repeat (600) step();
        check("rand_progress", 32'(log_id.size() > 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 16: the number of cycles allowed in START for tx_busy to rise; must be at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: bit i high means requester i offers a byte.
REQ-006 The block SHALL have port req_data, input, 8*NUM_REQ bits: the byte of requester i is bits [8i+7:8i].
REQ-007 The block SHALL have port req_last, input, NUM_REQ bits: high marks the byte of requester i as the final byte of its message.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: combinational accept strobe; a byte transfers on any cycle where req_valid[i] and req_ready[i] are both high.
REQ-009 The block SHALL have port tx_data, output, 8 bits: the byte to the serializer; registered.
REQ-010 The block SHALL have port tx_start, output, 1 bit: the start request to the serializer; registered.
REQ-011 The block SHALL have port tx_busy, input, 1 bit: the serializer busy flag.
REQ-012 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits: the index of the requester currently owning the serializer.
REQ-013 The block SHALL have port locked, output, 1 bit: high while a message is open, i.e. the last accepted byte had req_last=0.
REQ-014 The block SHALL have port err_timeout, output, 1 bit: a one-cycle pulse when tx_busy fails to rise within BUSY_TIMEOUT cycles.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, START and WAIT_DONE.
REQ-016 In IDLE with tx_busy=0, the block SHALL assert req_ready for exactly one requester, chosen as follows:
- unlocked: round-robin, the first valid index searching upward from ptr+1 modulo NUM_REQ;
- locked: grant_id only.
REQ-017 Whenever state is not IDLE, or tx_busy=1, req_ready SHALL be all zero.
REQ-018 On acceptance of a byte, the block SHALL:
- latch the byte into tx_data;
- set grant_id to the accepted index;
- set locked to the inverse of the accepted req_last;
- set tx_start=1 and enter START on the next cycle.
REQ-019 In START, tx_start SHALL stay high until the first cycle on which tx_busy=1; tx_start SHALL then clear and the FSM SHALL enter WAIT_DONE.
REQ-020 In START, a cycle counter SHALL count up; if it reaches BUSY_TIMEOUT before tx_busy=1, the block SHALL:
- pulse err_timeout for one cycle;
- clear tx_start and locked;
- drop the byte;
- advance ptr to grant_id;
- return to IDLE.
REQ-021 In WAIT_DONE, the FSM SHALL return to IDLE on the first cycle with tx_busy=0.
REQ-022 On return to IDLE from WAIT_DONE, ptr SHALL be set to grant_id only if locked=0; while locked=1, ptr SHALL hold.
REQ-023 The round-robin search SHALL wrap from index NUM_REQ-1 to index 0.
REQ-024 While locked, valid bytes from other requesters SHALL be ignored, with no starvation timeout.
REQ-025 If the locked requester deasserts req_valid, the block SHALL wait in IDLE indefinitely with locked=1.
REQ-026 tx_data SHALL hold its value from acceptance until the next acceptance.
REQ-027 Minimum latency SHALL be one cycle from acceptance to tx_start=1.
REQ-028 Throughput SHALL be one byte per serializer frame plus 2 cycles.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL set:
- state IDLE;
- tx_start=0 and tx_data=0x00;
- grant_id=0 and ptr=NUM_REQ-1, so that requester 0 has first priority;
- locked=0 and err_timeout=0;
- timeout counter 0.
REQ-030 req_ready SHALL be all zero during reset.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no further tx_start, and no byte SHALL be accepted in the cycle reset deasserts.

Verification
REQ-032 Simultaneous requests: requesters 0 and 2 valid, last=1, tx_busy model 10 cycles -> grants 0 then 2; tx_data 0x41 then 0x43; tx_start rises 1 cycle after each accept.
REQ-033 Wrap-around: ptr=3 with requesters 0 and 3 valid -> requester 0 granted first.
REQ-034 Lock: requester 1 sends 0x68,0x69 with last=0,1 while requester 0 is valid -> requester 1 sends both bytes back-to-back; locked goes 1 then 0; requester 0 is served next.
REQ-035 Timeout: tx_busy held at 0 after accept -> err_timeout pulses exactly at START cycle BUSY_TIMEOUT; tx_start=0 the following cycle; FSM back in IDLE; locked=0.
REQ-036 Busy gating: tx_busy=1 in IDLE with requests pending -> req_ready stays 0 until tx_busy falls.
REQ-037 Reset mid-frame: rst pulsed in WAIT_DONE -> all outputs at reset values the next cycle; requester 0 has first priority afterwards.
